// File: rtl/dds_pkg.sv
// Shared types and helpers for the quadrature NCO: quadrant encoding,
// quarter-wave folding and table sizing.
package dds_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  // Widest in-quadrant offset the fold helper supports (ADDR_W up to 18).
  localparam int unsigned MAX_A_W = 16;

  typedef struct packed {
    logic               negate;
    logic [MAX_A_W:0]   rom_addr;
  } fold_t;

  function automatic int unsigned quarter_points(input int unsigned addr_w);
    return 32'd1 << (addr_w - 32'd2);
  endfunction

  // Odd quadrants walk the table backwards from T[Q]; the lower half-cycle is negated.
  function automatic fold_t fold_idx(input quad_t quad, input logic [MAX_A_W-1:0] a,
                                     input int unsigned q);
    fold_t f;
    f.negate = (quad == Q2) || (quad == Q3);
    if ((quad == Q1) || (quad == Q3))
      f.rom_addr = (MAX_A_W + 1)'(q) - {1'b0, a};
    else
      f.rom_addr = {1'b0, a};
    return f;
  endfunction

endpackage

// File: rtl/dds_quad_nco_if.sv
// Control and sample bus of the quadrature NCO.
interface dds_quad_nco_if #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DATA_W  = 12
);
  logic               en;
  logic               phase_clr;
  logic [PHASE_W-1:0] fcw;
  logic [PHASE_W-1:0] phase_off;
  logic [DATA_W-1:0]  sin_out;
  logic [DATA_W-1:0]  cos_out;
  logic               out_valid;

  modport master (
    output en, phase_clr, fcw, phase_off,
    input  sin_out, cos_out, out_valid
  );

  modport slave (
    input  en, phase_clr, fcw, phase_off,
    output sin_out, cos_out, out_valid
  );
endinterface

// File: rtl/dds_qw_rom.sv
// Quarter-wave sine magnitude table, (Q+1) entries, two registered read ports.
// Contents are T[k] = round(A*sin(k*pi/(2Q))), built at elaboration.
module dds_qw_rom
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-2:0] addr_a,
  input  logic [ADDR_W-2:0] addr_b,
  output logic [DATA_W-2:0] data_a,
  output logic [DATA_W-2:0] data_b
);

  localparam int unsigned Q     = quarter_points(ADDR_W);
  localparam int unsigned DEPTH = Q + 1;
  localparam int unsigned MAG_W = DATA_W - 1;
  localparam longint      A     = (longint'(1) <<< MAG_W) - 1;
  localparam int unsigned FX    = 28;
  localparam longint      PI_FX = 64'sd843314857;

  // Fixed-point Taylor series (2^-28 scale, terms to x^17) so the table needs no real math.
  function automatic longint sin_mag(input longint k);
    longint x, term, sum, m;
    x    = (k * PI_FX) / (longint'(2) * longint'(Q));
    term = x;
    sum  = x;
    for (int unsigned n = 1; n <= 8; n++) begin
      term = (term * x) >>> FX;
      term = -(((term * x) >>> FX) / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    m = (A * sum + (longint'(1) <<< (FX - 1))) >>> FX;
    if (m < 0) m = 0;
    if (m > A) m = A;
    return m;
  endfunction

  logic [MAG_W-1:0] tbl [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    localparam longint M = sin_mag(longint'(k));
    assign tbl[k] = MAG_W'(M);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= tbl[addr_a];
      data_b <= tbl[addr_b];
    end
  end

endmodule

// File: rtl/dds_quad_nco.sv
// Quadrature NCO: phase accumulator with offset, quarter-wave fold to a shared
// table, and a 3-stage pipeline producing simultaneous sin and cos samples.
module dds_quad_nco
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 12,
  parameter bit          OFFSET_BIN = 1'b0,
  parameter string       INIT_FILE  = "dat/data_sin.dat"
) (
  input  logic           clk,
  input  logic           rst_n,
  dds_quad_nco_if.slave  io
);

  localparam int unsigned Q     = quarter_points(ADDR_W);
  localparam int unsigned A_W   = ADDR_W - 2;
  localparam int unsigned RA_W  = ADDR_W - 1;
  localparam int unsigned MAG_W = DATA_W - 1;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  p_sin;
  logic [ADDR_W-1:0]  p_cos;
  fold_t              f_sin;
  fold_t              f_cos;

  logic               s1_vld, s2_vld;
  logic [RA_W-1:0]    s1_addr_s, s1_addr_c;
  logic               s1_neg_s, s1_neg_c;
  logic               s2_neg_s, s2_neg_c;
  logic [MAG_W-1:0]   mag_s, mag_c;

  function automatic logic [DATA_W-1:0] fmt(input logic [MAG_W-1:0] mag, input logic neg);
    logic [DATA_W-1:0] v;
    v = {1'b0, mag};
    if (neg) v = -v;
    if (OFFSET_BIN) v[DATA_W-1] = ~v[DATA_W-1];
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             acc <= '0;
    else if (io.phase_clr)  acc <= '0;
    else if (io.en)         acc <= acc + io.fcw;
  end

  // S1 folds from the pre-increment accumulator, so a clear+enable edge still issues the old phase.
  always_comb begin
    phase = acc + io.phase_off;
    p_sin = phase[PHASE_W-1 -: ADDR_W];
    p_cos = p_sin + ADDR_W'(Q);
    f_sin = fold_idx(quad_t'(p_sin[ADDR_W-1 -: 2]), MAX_A_W'(p_sin[A_W-1:0]), Q);
    f_cos = fold_idx(quad_t'(p_cos[ADDR_W-1 -: 2]), MAX_A_W'(p_cos[A_W-1:0]), Q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_addr_s <= '0;
      s1_addr_c <= '0;
      s1_neg_s  <= 1'b0;
      s1_neg_c  <= 1'b0;
    end else begin
      s1_vld <= io.en;
      if (io.en) begin
        s1_addr_s <= RA_W'(f_sin.rom_addr);
        s1_addr_c <= RA_W'(f_cos.rom_addr);
        s1_neg_s  <= f_sin.negate;
        s1_neg_c  <= f_cos.negate;
      end
    end
  end

  dds_qw_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (s1_addr_s),
    .addr_b (s1_addr_c),
    .data_a (mag_s),
    .data_b (mag_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_neg_s <= 1'b0;
      s2_neg_c <= 1'b0;
    end else begin
      s2_vld   <= s1_vld;
      s2_neg_s <= s1_neg_s;
      s2_neg_c <= s1_neg_c;
    end
  end

  // Outputs only load on a valid slot, so bubbles leave the last sample in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.sin_out   <= '0;
      io.cos_out   <= '0;
    end else begin
      io.out_valid <= s2_vld;
      if (s2_vld) begin
        io.sin_out <= fmt(mag_s, s2_neg_s);
        io.cos_out <= fmt(mag_c, s2_neg_c);
      end
    end
  end

endmodule

// File: tb/tb_dds_quad_nco.sv
// Directed bench for dds_quad_nco (PHASE_W=32, ADDR_W=8, DATA_W=12), with a
// second instance in offset-binary mode driven from the same stimulus.
module tb_dds_quad_nco;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dds_quad_nco_if #(.PHASE_W(32), .DATA_W(12)) io ();
  dds_quad_nco_if #(.PHASE_W(32), .DATA_W(12)) iob ();

  assign iob.en        = io.en;
  assign iob.phase_clr = io.phase_clr;
  assign iob.fcw       = io.fcw;
  assign iob.phase_off = io.phase_off;

  dds_quad_nco #(
    .PHASE_W(32), .ADDR_W(8), .DATA_W(12), .OFFSET_BIN(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(io.slave)
  );

  dds_quad_nco #(
    .PHASE_W(32), .ADDR_W(8), .DATA_W(12), .OFFSET_BIN(1'b1)
  ) dut_ob (
    .clk(clk), .rst_n(rst_n), .io(iob.slave)
  );

  int checks = 0;
  int errors = 0;

  int          tbl [65];
  logic [31:0] macc;
  bit          hv [3];
  logic [11:0] hs [3];
  logic [11:0] hc [3];
  bit          ev;
  logic [11:0] es, ec;

  function automatic logic [11:0] model(input int idx);
    int quad, a, mag;
    logic [11:0] r;
    quad = (idx / 64) % 4;
    a    = idx % 64;
    mag  = (quad % 2 == 1) ? tbl[64 - a] : tbl[a];
    r    = 12'(mag);
    if (quad >= 2) r = -r;
    return r;
  endfunction

  task automatic model_reset();
    macc = '0;
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0; hs[i] = '0; hc[i] = '0;
    end
    ev = 1'b0; es = '0; ec = '0;
  endtask

  // Drive one clock of stimulus and advance the reference phase/delay line.
  task automatic step(input bit e, input bit c);
    logic [31:0] ph;
    int p;
    io.en = e;
    io.phase_clr = c;
    ph = macc + io.phase_off;
    p  = int'(ph[31:24]);
    hv[2] = hv[1]; hs[2] = hs[1]; hc[2] = hc[1];
    hv[1] = hv[0]; hs[1] = hs[0]; hc[1] = hc[0];
    hv[0] = e; hs[0] = model(p); hc[0] = model((p + 64) % 256);
    if (c) macc = '0;
    else if (e) macc = macc + io.fcw;
    @(posedge clk);
    #1;
    ev = hv[2];
    if (hv[2]) begin
      es = hs[2];
      ec = hc[2];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io.en = 1'b0; io.phase_clr = 1'b0; io.fcw = '0; io.phase_off = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", io.out_valid); end
    checks++; if (io.sin_out !== 12'h000) begin errors++; $display("FAIL reset_sin got %h want 000", io.sin_out); end
    checks++; if (io.cos_out !== 12'h000) begin errors++; $display("FAIL reset_cos got %h want 000", io.cos_out); end
    checks++; if (iob.sin_out !== 12'h000 || iob.cos_out !== 12'h000 || iob.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ob got %h/%h/%b want 000/000/0", iob.sin_out, iob.cos_out, iob.out_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b1);
    io.fcw = 32'h0100_0000;
    step(1'b1, 1'b0);
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n0 got %b want 0", io.out_valid); end
    step(1'b0, 1'b0);
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 got %b want 0", io.out_valid); end
    step(1'b0, 1'b0);
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL lat_n2 got %b want 1", io.out_valid); end
    checks++; if (io.sin_out !== 12'd0) begin errors++; $display("FAIL lat_sin got %0d want 0", io.sin_out); end
    checks++; if (io.cos_out !== 12'd2047) begin errors++; $display("FAIL lat_cos got %0d want 2047", io.cos_out); end
    step(1'b0, 1'b0);
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL lat_pulse got %b want 0", io.out_valid); end
  endtask

  task automatic test_quadrant_sweep();
    int n;
    logic [11:0] hsin [5];
    logic [11:0] hcos [5];
    hsin = '{12'd0, 12'd2047, 12'd0, 12'h801, 12'd0};
    hcos = '{12'd2047, 12'd0, 12'h801, 12'd0, 12'd2047};
    n = 0;
    io.fcw = 32'h0100_0000; io.phase_off = '0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 262; i++) begin
      step(i < 257, 1'b0);
      checks++; if (io.out_valid !== ev) begin errors++; $display("FAIL sweep_valid i=%0d got %b want %b", i, io.out_valid, ev); end
      if (ev) begin
        checks++; if (io.sin_out !== es || io.cos_out !== ec) begin
          errors++; $display("FAIL sweep_sample n=%0d got %h/%h want %h/%h", n, io.sin_out, io.cos_out, es, ec);
        end
        checks++; if (iob.sin_out !== (es ^ 12'h800) || iob.cos_out !== (ec ^ 12'h800)) begin
          errors++; $display("FAIL sweep_ob n=%0d got %h/%h want %h/%h", n, iob.sin_out, iob.cos_out, es ^ 12'h800, ec ^ 12'h800);
        end
        if (n % 64 == 0) begin
          checks++; if (io.sin_out !== hsin[n / 64] || io.cos_out !== hcos[n / 64]) begin
            errors++; $display("FAIL sweep_quad n=%0d got %h/%h want %h/%h", n, io.sin_out, io.cos_out, hsin[n / 64], hcos[n / 64]);
          end
        end
        n++;
      end
    end
    checks++; if (n !== 257) begin errors++; $display("FAIL sweep_count got %0d want 257", n); end
  endtask

  task automatic test_phase_offset();
    io.fcw = 32'h0100_0000; io.phase_off = 32'h4000_0000;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL off_valid got %b want 1", io.out_valid); end
    checks++; if (io.sin_out !== 12'd2047 || io.cos_out !== 12'd0) begin
      errors++; $display("FAIL off_sample got %0d/%0d want 2047/0", io.sin_out, io.cos_out);
    end
    checks++; if (iob.sin_out !== 12'hFFF || iob.cos_out !== 12'h800) begin
      errors++; $display("FAIL off_bin got %h/%h want fff/800", iob.sin_out, iob.cos_out);
    end
  endtask

  task automatic test_stall();
    bit          pat_en [7];
    bit          pat_v  [7];
    logic [11:0] pat_s  [7];
    logic [11:0] pat_c  [7];
    pat_en = '{1, 0, 0, 1, 0, 0, 0};
    pat_v  = '{0, 0, 1, 0, 0, 1, 0};
    pat_s  = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd50, 12'd50};
    pat_c  = '{12'd0, 12'd0, 12'd2047, 12'd2047, 12'd2047, 12'd2046, 12'd2046};
    io.fcw = 32'h0100_0000; io.phase_off = '0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(pat_en[k], 1'b0);
      checks++; if (io.out_valid !== pat_v[k]) begin errors++; $display("FAIL stall_valid k=%0d got %b want %b", k, io.out_valid, pat_v[k]); end
      if (k >= 2) begin
        checks++; if (io.sin_out !== pat_s[k] || io.cos_out !== pat_c[k]) begin
          errors++; $display("FAIL stall_hold k=%0d got %0d/%0d want %0d/%0d", k, io.sin_out, io.cos_out, pat_s[k], pat_c[k]);
        end
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (io.out_valid !== 1'b1 || io.sin_out !== 12'd100 || io.cos_out !== 12'd2045) begin
      errors++; $display("FAIL stall_advance got %b %0d/%0d want 1 100/2045", io.out_valid, io.sin_out, io.cos_out);
    end
  endtask

  task automatic test_wrap_collision();
    bit          s_en  [9];
    bit          s_clr [9];
    logic [11:0] h_s   [6];
    logic [11:0] h_c   [6];
    int n;
    s_en  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    s_clr = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    h_s   = '{12'd0, 12'hFCE, 12'hF9C, 12'hF6A, 12'd2046, 12'd2047};
    h_c   = '{12'd2047, 12'd2046, 12'd2045, 12'd2044, 12'd50, 12'd0};
    io.fcw = 32'hFFFF_FFFF; io.phase_off = '0;
    step(1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) io.phase_off = 32'h4000_0000;
      step(s_en[i], s_clr[i]);
      checks++; if (io.out_valid !== ev) begin errors++; $display("FAIL wrap_valid i=%0d got %b want %b", i, io.out_valid, ev); end
      if (ev) begin
        checks++; if ($isunknown({io.sin_out, io.cos_out}) || io.sin_out !== es || io.cos_out !== ec) begin
          errors++; $display("FAIL wrap_model n=%0d got %h/%h want %h/%h", n, io.sin_out, io.cos_out, es, ec);
        end
        if (n == 0 || n == 1 || n == 4 || n == 5) begin
          checks++; if (io.sin_out !== h_s[n] || io.cos_out !== h_c[n]) begin
            errors++; $display("FAIL wrap_hand n=%0d got %h/%h want %h/%h", n, io.sin_out, io.cos_out, h_s[n], h_c[n]);
          end
        end
        n++;
      end
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL wrap_count got %0d want 6", n); end
  endtask

  task automatic test_mid_reset();
    io.fcw = 32'h0100_0000; io.phase_off = '0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", io.out_valid); end
    #2;
    rst_n = 1'b0;
    io.en = 1'b0;
    #1;
    checks++; if (io.out_valid !== 1'b0 || io.sin_out !== 12'd0 || io.cos_out !== 12'd0) begin
      errors++; $display("FAIL mid_async got %b %h/%h want 0 000/000", io.out_valid, io.sin_out, io.cos_out);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale i=%0d got %b want 0", i, io.out_valid); end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (io.out_valid !== 1'b1 || io.sin_out !== 12'd0 || io.cos_out !== 12'd2047) begin
      errors++; $display("FAIL mid_restart got %b %0d/%0d want 1 0/2047", io.out_valid, io.sin_out, io.cos_out);
    end
  endtask

  initial begin
    for (int k = 0; k <= 64; k++)
      tbl[k] = $rtoi(2047.0 * $sin(real'(k) * 3.141592653589793 / 128.0) + 0.5);
    test_reset();
    test_quadrant_sweep();
    test_phase_offset();
    test_stall();
    test_wrap_collision();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
